// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings for the memory-access stage
package cpu_pkg;

  // Access size as carried by EX_MEM; 2'b11 is handled as a word
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - load lane select with sign/zero extension
module load_align
  import cpu_pkg::*;
(
  input  logic [31:0] memRdata,
  input  logic [1:0]  byteOff,
  input  logic [1:0]  size,
  input  logic        isSigned,
  output logic [31:0] loadData
);

  logic [31:0] lane;

  // Shift the addressed lane down to bit 0, then extend to 32 bits
  always_comb begin
    lane = memRdata >> {byteOff, 3'b000};
    case (size)
      SZ_BYTE: loadData = {{24{isSigned & lane[7]}}, lane[7:0]};
      SZ_HALF: loadData = {{16{isSigned & lane[15]}}, lane[15:0]};
      default: loadData = lane;  // words are aligned, so the shift is zero
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: load/store over a variable-latency data bus
module mem_access_stage
  import cpu_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        validIn,
  input  logic [31:0] aluIn,
  input  logic [31:0] storeIn,
  input  logic [4:0]  wnIn,
  input  logic        regWriteIn,
  input  logic        memToRegIn,
  input  logic        memReadIn,
  input  logic        memWriteIn,
  input  logic [1:0]  sizeIn,
  input  logic        signedIn,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [3:0]  memBe,
  input  logic        memAck,
  input  logic [31:0] memRdata,
  output logic [31:0] rdOut,
  output logic [31:0] aluOut,
  output logic [4:0]  wnOut,
  output logic        regWriteOut,
  output logic        memToRegOut,
  output logic        stall,
  output logic        misalign,
  output logic        busErr
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

  mem_state_t  state;
  logic [CW-1:0] waitCnt;
  logic [31:0] rdReg;
  logic        timeoutReg;  // high for the DONE cycle that follows an abort
  logic        memOp;
  logic        aligned;
  logic [3:0]  beNext;
  logic [31:0] wdataNext;
  logic [31:0] loadData;

  load_align uAlign (
    .memRdata (memRdata),
    .byteOff  (aluIn[1:0]),
    .size     (sizeIn),
    .isSigned (signedIn),
    .loadData (loadData)
  );

  // Decode the access: alignment, byte enables and lane-replicated store data
  always_comb begin
    memOp = validIn & (memReadIn | memWriteIn);
    case (sizeIn)
      SZ_BYTE: begin
        aligned   = 1'b1;
        beNext    = 4'b0001 << aluIn[1:0];
        wdataNext = {4{storeIn[7:0]}};
      end
      SZ_HALF: begin
        aligned   = ~aluIn[0];
        beNext    = 4'b0011 << aluIn[1:0];
        wdataNext = {2{storeIn[15:0]}};
      end
      SZ_WORD: begin
        aligned   = (aluIn[1:0] == 2'b00);
        beNext    = 4'b1111;
        wdataNext = storeIn;
      end
      default: begin
        aligned   = (aluIn[1:0] == 2'b00);
        beNext    = 4'b1111;
        wdataNext = storeIn;
      end
    endcase
  end

  // Write-back bundle and pipeline control; bubbles while a request is in flight
  always_comb begin
    aluOut      = aluIn;
    wnOut       = wnIn;
    rdOut       = rdReg;
    regWriteOut = 1'b0;
    memToRegOut = 1'b0;
    stall       = 1'b0;
    misalign    = 1'b0;
    busErr      = 1'b0;
    if (rst) begin
      case (state)
        ST_IDLE: begin
          if (!memOp) begin
            regWriteOut = regWriteIn & validIn;
            memToRegOut = memToRegIn & validIn;
          end else if (aligned) begin
            stall = 1'b1;
          end else begin
            misalign = 1'b1;
          end
        end
        ST_WAIT: stall = 1'b1;
        ST_DONE: begin
          regWriteOut = regWriteIn & validIn & ~timeoutReg;
          memToRegOut = memToRegIn & validIn;
          busErr      = timeoutReg;
        end
        default: stall = 1'b0;
      endcase
    end
  end

  // Request FSM: issue, wait for ack or timeout, then one DONE cycle for MEM_WB
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      memReq     <= 1'b0;
      memWe      <= 1'b0;
      memAddr    <= '0;
      memWdata   <= '0;
      memBe      <= '0;
      waitCnt    <= '0;
      rdReg      <= '0;
      timeoutReg <= 1'b0;
    end else begin
      timeoutReg <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (memOp && aligned) begin
            memReq   <= 1'b1;
            memWe    <= memWriteIn;
            memAddr  <= {aluIn[31:2], 2'b00};
            memBe    <= beNext;
            memWdata <= wdataNext;
            waitCnt  <= '0;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (memAck) begin
            rdReg  <= loadData;
            memReq <= 1'b0;
            memWe  <= 1'b0;
            state  <= ST_DONE;
          end else begin
            waitCnt <= waitCnt + CW'(1);
            if (waitCnt == CNT_LAST) begin
              rdReg      <= '0;
              memReq     <= 1'b0;
              memWe      <= 1'b0;
              timeoutReg <= 1'b1;
              state      <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage
module tb_mem_access_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        validIn = 1'b0;
  logic [31:0] aluIn = '0;
  logic [31:0] storeIn = '0;
  logic [4:0]  wnIn = '0;
  logic        regWriteIn = 1'b0;
  logic        memToRegIn = 1'b0;
  logic        memReadIn = 1'b0;
  logic        memWriteIn = 1'b0;
  logic [1:0]  sizeIn = '0;
  logic        signedIn = 1'b0;
  logic        memAck = 1'b0;
  logic [31:0] memRdata = '0;
  logic        memReq, memWe;
  logic [31:0] memAddr, memWdata;
  logic [3:0]  memBe;
  logic [31:0] rdOut, aluOut;
  logic [4:0]  wnOut;
  logic        regWriteOut, memToRegOut, stall, misalign, busErr;

  always #5 clk = ~clk;

  mem_access_stage #(.MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .validIn(validIn), .aluIn(aluIn), .storeIn(storeIn),
    .wnIn(wnIn), .regWriteIn(regWriteIn), .memToRegIn(memToRegIn),
    .memReadIn(memReadIn), .memWriteIn(memWriteIn), .sizeIn(sizeIn),
    .signedIn(signedIn), .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
    .memWdata(memWdata), .memBe(memBe), .memAck(memAck), .memRdata(memRdata),
    .rdOut(rdOut), .aluOut(aluOut), .wnOut(wnOut), .regWriteOut(regWriteOut),
    .memToRegOut(memToRegOut), .stall(stall), .misalign(misalign), .busErr(busErr)
  );

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  wn;
    logic        rw;
    logic        m2r;
    logic        rdCare;
    logic [31:0] rd;
    logic        mis;
    logic        berr;
  } commit_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic        wdCare;
    logic [31:0] wd;
  } bus_t;

  commit_t commitQ[$];
  bus_t    busQ[$];
  int compared = 0;
  int mismatched = 0;
  logic reqSeen = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pushCommit(input logic [31:0] alu, input logic [4:0] wn, input logic rw,
                            input logic m2r, input logic rdCare, input logic [31:0] rd,
                            input logic mis, input logic berr);
    commit_t c;
    c.alu = alu; c.wn = wn; c.rw = rw; c.m2r = m2r;
    c.rdCare = rdCare; c.rd = rd; c.mis = mis; c.berr = berr;
    commitQ.push_back(c);
  endtask

  task automatic pushBus(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic wdCare, input logic [31:0] wd);
    bus_t b;
    b.addr = addr; b.we = we; b.be = be; b.wdCare = wdCare; b.wd = wd;
    busQ.push_back(b);
  endtask

  // Monitor: a write-back commit is any unstalled cycle with a live instruction
  always @(negedge clk) begin
    commit_t c;
    bus_t b;
    if (rst && validIn && !stall) begin
      if (commitQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL commit: unexpected write-back aluOut 0x%08h expected none", aluOut);
      end else begin
        c = commitQ.pop_front();
        check32("aluOut", aluOut, c.alu);
        check32("wnOut", {27'd0, wnOut}, {27'd0, c.wn});
        checkBit("regWriteOut", regWriteOut, c.rw);
        checkBit("memToRegOut", memToRegOut, c.m2r);
        checkBit("misalign", misalign, c.mis);
        checkBit("busErr", busErr, c.berr);
        if (c.rdCare) check32("rdOut", rdOut, c.rd);
      end
    end
    if (memReq && !reqSeen) begin
      if (busQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL memReq: unexpected request addr 0x%08h expected none", memAddr);
      end else begin
        b = busQ.pop_front();
        check32("memAddr", memAddr, b.addr);
        checkBit("memWe", memWe, b.we);
        check32("memBe", {28'd0, memBe}, {28'd0, b.be});
        if (b.wdCare) check32("memWdata", memWdata, b.wd);
      end
    end
    reqSeen <= memReq;
  end

  // Drive one instruction, answer the bus after ackAt WAIT cycles (0 = never)
  task automatic runOp(input string name, input logic [31:0] alu, input logic [31:0] st,
                       input logic [4:0] wn, input logic rw, input logic m2r,
                       input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sg, input int ackAt, input logic [31:0] rdata,
                       input int expStall);
    int stallCnt = 0;
    int waitN = 0;
    logic released = 1'b0;
    aluIn = alu; storeIn = st; wnIn = wn; regWriteIn = rw; memToRegIn = m2r;
    memReadIn = rd; memWriteIn = wr; sizeIn = sz; signedIn = sg; validIn = 1'b1;
    for (int cyc = 0; cyc < 64; cyc++) begin
      @(negedge clk);
      if (!stall) begin
        released = 1'b1;
        break;
      end
      stallCnt++;
      if (memReq) begin
        waitN++;
        memAck = (ackAt > 0) && (waitN == ackAt);
        memRdata = rdata;
      end
    end
    memAck = 1'b0;
    checkBit({name, " released"}, released, 1'b1);
    checkInt({name, " stall cycles"}, stallCnt, expStall);
    @(posedge clk);
    #1;
    validIn = 1'b0; memReadIn = 1'b0; memWriteIn = 1'b0;
    regWriteIn = 1'b0; memToRegIn = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a live load presented: everything held quiet
    validIn = 1'b1; memReadIn = 1'b1; regWriteIn = 1'b1; memToRegIn = 1'b1;
    aluIn = 32'h100; sizeIn = SZ_WORD;
    repeat (2) @(negedge clk);
    checkBit("rst regWriteOut", regWriteOut, 1'b0);
    checkBit("rst memToRegOut", memToRegOut, 1'b0);
    checkBit("rst stall", stall, 1'b0);
    checkBit("rst memReq", memReq, 1'b0);
    checkBit("rst misalign", misalign, 1'b0);
    checkBit("rst busErr", busErr, 1'b0);
    check32("rst rdOut", rdOut, 32'h0);
    @(posedge clk); #1;
    validIn = 1'b0; memReadIn = 1'b0; regWriteIn = 1'b0; memToRegIn = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    // ALU pass-through
    pushCommit(32'h1234, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    runOp("alu", 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 0, 32'h0, 0);

    // lw, ack on third WAIT cycle
    pushBus(32'h100, 1'b0, 4'b1111, 1'b0, 32'h0);
    pushCommit(32'h100, 5'd8, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    runOp("lw", 32'h100, 32'h0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 3, 32'hDEADBEEF, 4);

    // lb / lbu from top byte
    pushBus(32'h100, 1'b0, 4'b1000, 1'b0, 32'h0);
    pushCommit(32'h103, 5'd9, 1'b1, 1'b1, 1'b1, 32'hFFFFFF80, 1'b0, 1'b0);
    runOp("lb", 32'h103, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, SZ_BYTE, 1'b1, 1, 32'h80123456, 2);
    pushBus(32'h100, 1'b0, 4'b1000, 1'b0, 32'h0);
    pushCommit(32'h103, 5'd10, 1'b1, 1'b1, 1'b1, 32'h00000080, 1'b0, 1'b0);
    runOp("lbu", 32'h103, 32'h0, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, SZ_BYTE, 1'b0, 1, 32'h80123456, 2);

    // lh upper half signed, lhu lower half
    pushBus(32'h100, 1'b0, 4'b1100, 1'b0, 32'h0);
    pushCommit(32'h102, 5'd11, 1'b1, 1'b1, 1'b1, 32'hFFFF8001, 1'b0, 1'b0);
    runOp("lh", 32'h102, 32'h0, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, SZ_HALF, 1'b1, 2, 32'h80017FFF, 3);
    pushBus(32'h100, 1'b0, 4'b0011, 1'b0, 32'h0);
    pushCommit(32'h100, 5'd12, 1'b1, 1'b1, 1'b1, 32'h0000F00D, 1'b0, 1'b0);
    runOp("lhu", 32'h100, 32'h0, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, SZ_HALF, 1'b0, 1, 32'h8001F00D, 2);

    // lbu lowest byte
    pushBus(32'h100, 1'b0, 4'b0001, 1'b0, 32'h0);
    pushCommit(32'h100, 5'd13, 1'b1, 1'b1, 1'b1, 32'h000000DD, 1'b0, 1'b0);
    runOp("lbu0", 32'h100, 32'h0, 5'd13, 1'b1, 1'b1, 1'b1, 1'b0, SZ_BYTE, 1'b0, 1, 32'hAABBCCDD, 2);

    // Stores
    pushBus(32'h100, 1'b1, 4'b1100, 1'b1, 32'hABCDABCD);
    pushCommit(32'h102, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    runOp("sh", 32'h102, 32'h0000ABCD, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, SZ_HALF, 1'b0, 2, 32'h0, 3);
    pushBus(32'h100, 1'b1, 4'b0010, 1'b1, 32'h78787878);
    pushCommit(32'h101, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    runOp("sb", 32'h101, 32'h12345678, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, SZ_BYTE, 1'b0, 1, 32'h0, 2);

    // Misaligned: no request, write-back suppressed
    pushCommit(32'h101, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    runOp("sh mis", 32'h101, 32'h0000ABCD, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, SZ_HALF, 1'b0, 0, 32'h0, 0);
    pushCommit(32'h102, 5'd14, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    runOp("lw mis", 32'h102, 32'h0, 5'd14, 1'b1, 1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 0, 32'h0, 0);
    @(negedge clk);
    checkBit("misalign pulse end", misalign, 1'b0);
    @(posedge clk); #1;

    // Timeout after 15 WAIT cycles
    pushBus(32'h104, 1'b0, 4'b1111, 1'b0, 32'h0);
    pushCommit(32'h104, 5'd15, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1);
    runOp("lw tmo", 32'h104, 32'h0, 5'd15, 1'b1, 1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 0, 32'h0, 16);
    checkBit("busErr pulse end", busErr, 1'b0);

    // Ack on the last allowed WAIT cycle wins over timeout
    pushBus(32'h108, 1'b0, 4'b1111, 1'b0, 32'h0);
    pushCommit(32'h108, 5'd16, 1'b1, 1'b1, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0);
    runOp("lw ack15", 32'h108, 32'h0, 5'd16, 1'b1, 1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 15, 32'hCAFEF00D, 16);

    // Size 2'b11 behaves as a word
    pushBus(32'h104, 1'b0, 4'b1111, 1'b0, 32'h0);
    pushCommit(32'h104, 5'd17, 1'b1, 1'b1, 1'b1, 32'h0BADF00D, 1'b0, 1'b0);
    runOp("lw sz3", 32'h104, 32'h0, 5'd17, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 1, 32'h0BADF00D, 2);

    // Reset in the middle of WAIT drops the request; a late ack does nothing
    pushBus(32'h200, 1'b0, 4'b1111, 1'b0, 32'h0);
    aluIn = 32'h200; memReadIn = 1'b1; regWriteIn = 1'b1; memToRegIn = 1'b1;
    sizeIn = SZ_WORD; wnIn = 5'd3; validIn = 1'b1;
    repeat (3) @(negedge clk);
    checkBit("pre-rst stall", stall, 1'b1);
    checkBit("pre-rst memReq", memReq, 1'b1);
    rst = 1'b0;
    validIn = 1'b0; memReadIn = 1'b0; regWriteIn = 1'b0; memToRegIn = 1'b0;
    #1;
    checkBit("rst comb stall", stall, 1'b0);
    @(negedge clk);
    checkBit("rst memReq drop", memReq, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    memAck = 1'b1;
    memRdata = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    checkBit("late ack memReq", memReq, 1'b0);
    checkBit("late ack stall", stall, 1'b0);
    check32("late ack rdOut", rdOut, 32'h0);
    memAck = 1'b0;
    @(posedge clk); #1;

    // Back in IDLE: pass-through with zero latency
    pushCommit(32'h55AA, 5'd31, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    runOp("alu post-rst", 32'h55AA, 32'h0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 0, 32'h0, 0);

    repeat (2) @(negedge clk);
    checkInt("commit queue drained", commitQ.size(), 0);
    checkInt("bus queue drained", busQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MIPS 5-stage pipeline memory-access stage: consumes the EX_MEM register outputs, performs byte/half/word loads and stores over a variable-latency data-memory handshake, and produces the write-back bundle latched by the MEM_WB register. It stalls the front of the pipeline while a memory transaction is outstanding, suppresses write-back on misaligned or timed-out accesses, and flags those events.

## Interface
- MAX_WAIT, 15 — maximum cycles in WAIT without memAck before abort; counter width $clog2(MAX_WAIT+1)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-low (asserted when 0)
- validIn  input  1  EX_MEM holds a live instruction
- aluIn  input  32  ALU result / effective address
- storeIn  input  32  store data (rt)
- wnIn  input  5  destination register
- regWriteIn, memToRegIn, memReadIn, memWriteIn  input  1 each  control from EX_MEM
- sizeIn  input  2  00 byte, 01 half, 10 word (11 treated as word)
- signedIn  input  1  1 = sign-extend loads (lb/lh), 0 = zero-extend (lbu/lhu)
- memReq  output  1  bus request, registered
- memWe  output  1  1 = store
- memAddr  output  32  word-aligned address {aluIn[31:2],2'b00}
- memWdata  output  32  lane-replicated store data
- memBe  output  4  byte enables
- memAck  input  1  completes current request
- memRdata  input  32  read data, valid when memAck=1
- rdOut, aluOut  output  32  load data / ALU result to MEM_WB
- wnOut  output  5  destination to MEM_WB
- regWriteOut, memToRegOut  output  1  to MEM_WB
- stall  output  1  freeze PC, IF_ID, ID_EX, EX_MEM
- misalign  output  1  one-cycle pulse, misaligned access dropped
- busErr  output  1  one-cycle pulse, MAX_WAIT timeout

## Operation
- memOp = validIn & (memReadIn | memWriteIn); aligned = byte, or half & addr[0]=0, or word & addr[1:0]=0.
- FSM IDLE / WAIT / DONE.
- IDLE: non-memOp → pass-through (aluOut=aluIn, wnOut=wnIn, regWriteOut=regWriteIn&validIn, memToRegOut=memToRegIn&validIn), stall=0. memOp & aligned → stall=1, register memReq=1, memWe, memBe, memWdata; next WAIT. memOp & misaligned → no request, stall=0, regWriteOut=0, misalign=1; stay IDLE.
- WAIT: stall=1, memReq held, counter increments. memAck → capture formatted load data into rdReg, memReq=0, next DONE. Counter reaching MAX_WAIT without ack → memReq=0, busErr=1, regWriteOut=0 for this instruction, next DONE with rdReg=0.
- DONE: stall=0, outputs driven from EX_MEM inputs, rdOut=rdReg, regWriteOut forced 0 on timeout; MEM_WB latches at this edge; next IDLE.
- Byte enables (little-endian): byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
- memWdata: byte {4{st[7:0]}}, half {2{st[15:0]}}, word st.
- Load format: lane = memRdata>>(8*addr[1:0]); byte/half sign- or zero-extended per signedIn; word unchanged.
- Stores: rdOut don't-care, regWriteOut follows regWriteIn (0 for sw/sb/sh).
- Outside DONE, rdOut=rdReg unchanged.

## Timing
- Reset (rst=0 at edge): state IDLE, memReq=0, counter=0, rdReg=0. While rst=0, regWriteOut, memToRegOut, stall, misalign, busErr forced 0 combinationally. Reset mid-WAIT drops the request; a late memAck is ignored.
- Non-memory op: zero added latency, combinational pass-through.
- Memory op with memAck in first WAIT cycle: 3 cycles (IDLE, WAIT, DONE); each extra wait cycle adds one.
- memAck sampled only in WAIT; ack in IDLE/DONE ignored.
- memAck on the same edge the counter reaches MAX_WAIT: ack wins, no busErr.
- Inputs required stable while stall=1 (EX_MEM frozen by stall).
- misalign and busErr are one-cycle pulses.

## Structure
- Shared package cpu_pkg: size encodings SZ_BYTE/SZ_HALF/SZ_WORD, FSM state typedef mem_state_t.
- Sub-module load_align: combinational lane select plus sign/zero extension (memRdata, addr[1:0], size, signed → 32-bit).

## Test plan
- ALU op aluIn=0x1234, wnIn=5, regWriteIn=1 → same cycle aluOut=0x1234, wnOut=5, regWriteOut=1, stall=0.
- lw addr 0x100, ack after 2 wait cycles, rdata 0xDEADBEEF → stall high 4 cycles, memBe=1111, rdOut=0xDEADBEEF in DONE.
- lb addr 0x103 signed, rdata 0x80xxxxxx → memBe=1000, rdOut=0xFFFFFF80; lbu same → 0x00000080.
- sh addr 0x102 store 0x0000ABCD → memBe=1100, memWdata=0xABCDABCD, memWe=1; sh addr 0x101 → misalign pulse, no memReq, regWriteOut=0.
- lw with memAck never asserted, MAX_WAIT=15 → busErr pulse after 15 WAIT cycles, regWriteOut=0 in DONE, stall drops.
- rst=0 during WAIT → next cycle memReq=0, state IDLE, stall=0; memAck arriving afterward has no effect.
